// File: rtl/adsr_pkg.sv
// Shared state encoding and default envelope constants for the ADSR stage.
package adsr_pkg;

  localparam int unsigned STATE_WDTH = 3;

  typedef enum logic [STATE_WDTH-1:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  localparam int unsigned DEF_DATA_WDTH    = 24;
  localparam int unsigned DEF_ENV_WDTH     = 16;
  localparam int unsigned DEF_ATTACK_STEP  = 64;
  localparam int unsigned DEF_DECAY_STEP   = 16;
  localparam int unsigned DEF_SUSTAIN_LVL  = 'hC000;
  localparam int unsigned DEF_RELEASE_STEP = 32;

endpackage

// File: rtl/env_scaler.sv
// Registered signed sample x unsigned envelope level, floor-shifted back to sample width.
module env_scaler #(
  parameter int unsigned DATA_WDTH = 24,
  parameter int unsigned ENV_WDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic signed [DATA_WDTH-1:0] sample,
  input  logic        [ENV_WDTH-1:0]  level,
  output logic signed [DATA_WDTH-1:0] scaled
);

  localparam int unsigned PROD_WDTH = DATA_WDTH + ENV_WDTH + 1;

  logic signed [PROD_WDTH-1:0] sample_ext;
  logic signed [PROD_WDTH-1:0] level_ext;
  logic signed [PROD_WDTH-1:0] prod;

  // Zero-extend the level so it multiplies as a non-negative signed operand
  always_comb begin
    sample_ext = PROD_WDTH'(sample);
    level_ext  = signed'(PROD_WDTH'({1'b0, level}));
    prod       = sample_ext * level_ext;
  end

  // Capture the floor-shifted product on each sample request, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scaled <= '0;
    end else if (en) begin
      scaled <= DATA_WDTH'(prod >>> ENV_WDTH);
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: note events drive the state machine, sample requests step the level.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int unsigned DATA_WDTH    = DEF_DATA_WDTH,
  parameter int unsigned ENV_WDTH     = DEF_ENV_WDTH,
  parameter int unsigned ATTACK_STEP  = DEF_ATTACK_STEP,
  parameter int unsigned DECAY_STEP   = DEF_DECAY_STEP,
  parameter int unsigned SUSTAIN_LVL  = DEF_SUSTAIN_LVL,
  parameter int unsigned RELEASE_STEP = DEF_RELEASE_STEP
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        note_on,
  input  logic                        note_off,
  input  logic                        sample_req,
  input  logic signed [DATA_WDTH-1:0] sine_in,
  output logic signed [DATA_WDTH-1:0] sample_out,
  output logic        [ENV_WDTH-1:0]  env_level,
  output logic        [STATE_WDTH-1:0] env_state,
  output logic                        busy
);

  localparam int unsigned LW = ENV_WDTH + 1;
  localparam logic [LW-1:0] MAX_W = {1'b0, {ENV_WDTH{1'b1}}};

  adsr_state_e          state;
  adsr_state_e          state_nxt;
  logic [ENV_WDTH-1:0]  level;
  logic [ENV_WDTH-1:0]  level_nxt;
  logic [LW-1:0]        level_w;
  logic [LW-1:0]        att_sum;
  logic [LW-1:0]        rel_diff;
  logic signed [LW-1:0] dec_diff;

  // Widened step arithmetic so no add/subtract can wrap before clamping
  always_comb begin
    level_w  = {1'b0, level};
    att_sum  = level_w + LW'(ATTACK_STEP);
    dec_diff = signed'(level_w - LW'(DECAY_STEP));
    rel_diff = level_w - LW'(RELEASE_STEP);
  end

  // Next state and level: events take priority over stepping
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    case (state)
      ST_IDLE: begin
        if (note_on) state_nxt = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (note_on) begin
          state_nxt = ST_ATTACK;
        end else if (note_off) begin
          state_nxt = ST_RELEASE;
        end else if (sample_req) begin
          if (att_sum >= MAX_W) begin
            level_nxt = ENV_WDTH'(MAX_W);
            state_nxt = ST_DECAY;
          end else begin
            level_nxt = ENV_WDTH'(att_sum);
          end
        end
      end
      ST_DECAY: begin
        if (note_on) begin
          state_nxt = ST_ATTACK;
        end else if (note_off) begin
          state_nxt = ST_RELEASE;
        end else if (sample_req) begin
          if (dec_diff <= signed'(LW'(SUSTAIN_LVL))) begin
            level_nxt = ENV_WDTH'(SUSTAIN_LVL);
            state_nxt = ST_SUSTAIN;
          end else begin
            level_nxt = ENV_WDTH'(dec_diff);
          end
        end
      end
      ST_SUSTAIN: begin
        if (note_on)       state_nxt = ST_ATTACK;
        else if (note_off) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (note_on) begin
          state_nxt = ST_ATTACK;
        end else if (!note_off && sample_req) begin
          if (level_w <= LW'(RELEASE_STEP)) begin
            level_nxt = '0;
            state_nxt = ST_IDLE;
          end else begin
            level_nxt = ENV_WDTH'(rel_diff);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        level_nxt = '0;
      end
    endcase
  end

  // State, level and busy registers; reset aborts any note without a tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      level <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  assign env_state = state;
  assign env_level = level;

  env_scaler #(
    .DATA_WDTH (DATA_WDTH),
    .ENV_WDTH  (ENV_WDTH)
  ) u_scaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (sample_req),
    .sample (sine_in),
    .level  (level),
    .scaled (sample_out)
  );

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope against an arithmetic envelope model.
module tb_adsr_envelope;

  localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;
  localparam int MAXL = 65535, SUS = 49152;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        note_on = 1'b0;
  logic        note_off = 1'b0;
  logic        sample_req = 1'b0;
  logic [23:0] sine_in = '0;
  logic [23:0] sample_out;
  logic [15:0] env_level;
  logic [2:0]  env_state;
  logic        busy;

  int          vectors = 0;
  int          errors = 0;
  int          m_state = S_IDLE;
  int          m_level = 0;
  logic [23:0] m_out = '0;

  adsr_envelope dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_on    (note_on),
    .note_off   (note_off),
    .sample_req (sample_req),
    .sine_in    (sine_in),
    .sample_out (sample_out),
    .env_level  (env_level),
    .env_state  (env_state),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] scale(input logic [23:0] s, input int lvl);
    longint p, q;
    p = longint'($signed(s)) * longint'(lvl);
    q = p / 65536;
    if (p < 0 && (p % 65536) != 0) q = q - 1;
    return q[23:0];
  endfunction

  // Apply one clock of stimulus and advance the reference model
  task automatic drive(input bit on, input bit off, input bit req, input logic [23:0] sine);
    int pre;
    pre = m_level;
    note_on = on; note_off = off; sample_req = req; sine_in = sine;
    @(posedge clk); #1;
    note_on = 0; note_off = 0; sample_req = 0;
    if (req) m_out = scale(sine, pre);
    if (on) begin
      m_state = S_ATT;
    end else if (off) begin
      if (m_state == S_ATT || m_state == S_DEC || m_state == S_SUS) m_state = S_REL;
    end else if (req) begin
      case (m_state)
        S_ATT: if (pre + 64 >= MAXL) begin m_level = MAXL; m_state = S_DEC; end
               else m_level = pre + 64;
        S_DEC: if (pre - 16 <= SUS) begin m_level = SUS; m_state = S_SUS; end
               else m_level = pre - 16;
        S_REL: if (pre <= 32) begin m_level = 0; m_state = S_IDLE; end
               else m_level = pre - 32;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    vectors++;
    if (env_level !== 16'd0 || env_state !== 3'd0 || sample_out !== 24'd0 || busy !== 1'b0) begin
      $display("FAIL reset_state level=%h state=%0d out=%h busy=%b want 0/0/0/0",
               env_level, env_state, sample_out, busy);
      errors++;
    end
  endtask

  task automatic test_idle_scaling;
    drive(0, 0, 1, 24'h7FFFFF);
    vectors++;
    if (sample_out !== 24'h0 || env_state !== 3'd0) begin
      $display("FAIL idle_scale out=%h state=%0d want 000000/0", sample_out, env_state);
      errors++;
    end
  endtask

  task automatic test_attack;
    drive(1, 0, 0, '0);
    vectors++;
    if (env_state !== 3'(S_ATT) || env_level !== 16'd0 || busy !== 1'b1) begin
      $display("FAIL attack_entry state=%0d level=%h busy=%b want 1/0000/1", env_state, env_level, busy);
      errors++;
    end
    for (int k = 1; k <= 1024; k++) begin
      drive(0, 0, 1, 24'($urandom));
      vectors++;
      if (env_level !== 16'(m_level) || env_state !== 3'(m_state) || sample_out !== m_out) begin
        $display("FAIL attack_step k=%0d level=%h state=%0d out=%h want %h/%0d/%h",
                 k, env_level, env_state, sample_out, 16'(m_level), m_state, m_out);
        errors++;
      end
      if (k == 1023) begin
        vectors++;
        if (env_level !== 16'(64 * 1023)) begin
          $display("FAIL attack_1023 level=%h want %h", env_level, 16'(64 * 1023));
          errors++;
        end
      end
    end
    vectors++;
    if (env_level !== 16'hFFFF || env_state !== 3'(S_DEC)) begin
      $display("FAIL attack_clamp level=%h state=%0d want ffff/2", env_level, env_state);
      errors++;
    end
  endtask

  task automatic test_decay_sustain(input logic [23:0] first_sine, input logic [23:0] first_exp);
    for (int k = 1; k <= 1024; k++) begin
      drive(0, 0, 1, (k == 1) ? first_sine : 24'($urandom));
      vectors++;
      if (env_level !== 16'(m_level) || env_state !== 3'(m_state) || sample_out !== m_out) begin
        $display("FAIL decay_step k=%0d level=%h state=%0d out=%h want %h/%0d/%h",
                 k, env_level, env_state, sample_out, 16'(m_level), m_state, m_out);
        errors++;
      end
      if (k == 1) begin
        vectors++;
        if (sample_out !== first_exp) begin
          $display("FAIL full_scale_mult out=%h want %h", sample_out, first_exp);
          errors++;
        end
      end
      if (k == 1023) begin
        vectors++;
        if (env_level !== 16'hC00F || env_state !== 3'(S_DEC)) begin
          $display("FAIL decay_1023 level=%h state=%0d want c00f/2", env_level, env_state);
          errors++;
        end
      end
    end
    vectors++;
    if (env_level !== 16'hC000 || env_state !== 3'(S_SUS)) begin
      $display("FAIL sustain_entry level=%h state=%0d want c000/3", env_level, env_state);
      errors++;
    end
    repeat (5) drive(0, 0, 1, 24'h123456);
    vectors++;
    if (env_level !== 16'hC000 || env_state !== 3'(S_SUS) || sample_out !== scale(24'h123456, SUS)) begin
      $display("FAIL sustain_hold level=%h state=%0d out=%h want c000/3/%h",
               env_level, env_state, sample_out, scale(24'h123456, SUS));
      errors++;
    end
  endtask

  task automatic test_reset_mid_sustain;
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    vectors++;
    if (env_level !== 16'd0 || env_state !== 3'd0 || sample_out !== 24'd0 || busy !== 1'b0) begin
      $display("FAIL async_reset level=%h state=%0d out=%h busy=%b want 0/0/0/0",
               env_level, env_state, sample_out, busy);
      errors++;
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    m_state = S_IDLE; m_level = 0; m_out = '0;
    @(posedge clk); #1;
    vectors++;
    if (env_state !== 3'd0 || busy !== 1'b0) begin
      $display("FAIL post_reset state=%0d busy=%b want 0/0", env_state, busy);
      errors++;
    end
  endtask

  task automatic test_release;
    drive(0, 1, 0, '0);
    vectors++;
    if (env_state !== 3'(S_REL) || env_level !== 16'hC000) begin
      $display("FAIL release_entry state=%0d level=%h want 4/c000", env_state, env_level);
      errors++;
    end
    for (int k = 1; k <= 1536; k++) begin
      drive(0, 0, 1, 24'($urandom));
      vectors++;
      if (env_level !== 16'(m_level) || env_state !== 3'(m_state) || sample_out !== m_out) begin
        $display("FAIL release_step k=%0d level=%h state=%0d out=%h want %h/%0d/%h",
                 k, env_level, env_state, sample_out, 16'(m_level), m_state, m_out);
        errors++;
      end
      if (k == 1535) begin
        vectors++;
        if (env_level !== 16'd32) begin
          $display("FAIL release_1535 level=%h want 0020", env_level);
          errors++;
        end
      end
    end
    vectors++;
    if (env_level !== 16'd0 || env_state !== 3'(S_IDLE) || busy !== 1'b0) begin
      $display("FAIL release_end level=%h state=%0d busy=%b want 0/0/0", env_level, env_state, busy);
      errors++;
    end
  endtask

  task automatic test_same_cycle;
    drive(1, 0, 0, '0);
    repeat (1024) drive(0, 0, 1, '0);
    repeat (1024) drive(0, 0, 1, '0);
    drive(0, 1, 0, '0);
    repeat (1408) drive(0, 0, 1, '0);
    vectors++;
    if (env_level !== 16'h1000 || env_state !== 3'(S_REL)) begin
      $display("FAIL release_at_1000 level=%h state=%0d want 1000/4", env_level, env_state);
      errors++;
    end
    drive(1, 1, 1, 24'h400000);
    vectors++;
    if (env_state !== 3'(S_ATT) || env_level !== 16'h1000 || sample_out !== 24'h040000) begin
      $display("FAIL on_off_req state=%0d level=%h out=%h want 1/1000/040000",
               env_state, env_level, sample_out);
      errors++;
    end
    drive(0, 0, 1, '0);
    vectors++;
    if (env_level !== 16'h1040 || env_state !== 3'(S_ATT)) begin
      $display("FAIL retrigger_step level=%h state=%0d want 1040/1", env_level, env_state);
      errors++;
    end
  endtask

  task automatic test_random;
    bit on, off, req;
    for (int i = 0; i < 6000; i++) begin
      on  = ($urandom_range(0, 299) == 0);
      off = ($urandom_range(0, 199) == 0);
      req = ($urandom_range(0, 1) == 0);
      drive(on, off, req, 24'($urandom));
      vectors++;
      if (env_level !== 16'(m_level) || env_state !== 3'(m_state) || sample_out !== m_out ||
          busy !== (m_state != S_IDLE)) begin
        $display("FAIL random i=%0d level=%h state=%0d out=%h busy=%b want %h/%0d/%h/%b",
                 i, env_level, env_state, sample_out, busy, 16'(m_level), m_state, m_out,
                 m_state != S_IDLE);
        errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scaling();
    test_attack();
    test_decay_sustain(24'h400000, 24'h3FFFC0);
    test_reset_mid_sustain();
    test_attack();
    test_decay_sustain(24'hC00000, 24'hC00040);
    test_release();
    test_same_cycle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
